// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button edge events, run/pause/limit/load FSM, speed-scaled tick prescaler.
// Optional STOPWATCH_CTRL_SYNC_EN adds 2-flop synchronizers on buttons and REVERSE (+2 cycles event latency).
module stopwatch_ctrl #(
   parameter int TICK_DIV = 1000
) (
   input  logic       clk_in,
   input  logic       RESET_N,
   input  logic       START_BTN,
   input  logic       RESET_BTN,
   input  logic       ADD_BTN,
   input  logic       SUB_BTN,
   input  logic       SPEED_UP,
   input  logic       SPEED_DOWN,
   input  logic       REVERSE,
   input  logic       AT_LIMIT,
   output logic       TICK_EN,
   output logic       LOAD,
   output logic [1:0] LOAD_SEL,
   output logic       RUNNING,
   output logic [1:0] SPEED,
   output logic [2:0] STATE
);

   localparam logic [2:0] ST_IDLE  = 3'b000;
   localparam logic [2:0] ST_RUN   = 3'b001;
   localparam logic [2:0] ST_PAUSE = 3'b010;
   localparam logic [2:0] ST_LIMIT = 3'b011;
   localparam logic [2:0] ST_LOAD  = 3'b100;

   localparam int CW = $clog2(TICK_DIV);
   // TICK_DIV is a multiple of 8, so (TICK_DIV >> s) - 1 == (TICK_DIV - 1) >> s for s <= 3.
   localparam logic [CW-1:0] LIM0 = CW'(TICK_DIV - 1);

   logic [2:0]    r_state;
   logic [6:0]    r_prev;
   logic [1:0]    r_speed;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_load_sel;

   logic [6:0]    w_raw;
   logic [6:0]    w_lvl;
   logic [5:0]    w_rise;
   logic          w_rev_chg;
   logic          w_ev_load;
   logic          w_ev_start;
   logic [1:0]    w_sel_nxt;
   logic [2:0]    w_state_nxt;
   logic [1:0]    w_speed_nxt;
   logic [CW-1:0] w_lim;
   logic [CW-1:0] w_cnt_nxt;

   assign w_raw = {REVERSE, SPEED_DOWN, SPEED_UP, START_BTN, ADD_BTN, SUB_BTN, RESET_BTN};

`ifdef STOPWATCH_CTRL_SYNC_EN
   logic [6:0] r_sync1;
   logic [6:0] r_sync2;

   always_ff @(posedge clk_in or negedge RESET_N) begin
      if (!RESET_N) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_lvl = r_sync2;
`else
   assign w_lvl = w_raw;
`endif

   assign w_rise    = w_lvl[5:0] & ~r_prev[5:0];
   assign w_rev_chg = w_lvl[6] ^ r_prev[6];

   // Priority RESET > SUB > ADD > START; a lower event in the same cycle is discarded.
   assign w_ev_load  = |w_rise[2:0];
   assign w_ev_start = w_rise[3] & ~w_ev_load;
   assign w_sel_nxt  = w_rise[0] ? {1'b0, w_lvl[6]} :
                       w_rise[1] ? 2'b11 : 2'b10;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_PAUSE: begin
            if (w_ev_load)
               w_state_nxt = ST_LOAD;
            else if (w_ev_start)
               w_state_nxt = AT_LIMIT ? ST_LIMIT : ST_RUN;
         end
         ST_RUN: begin
            if (w_rise[0])
               w_state_nxt = ST_LOAD;
            else if (w_ev_start)
               w_state_nxt = ST_PAUSE;
            else if (AT_LIMIT)
               w_state_nxt = ST_LIMIT;
         end
         ST_LIMIT: begin
            if (w_ev_load)
               w_state_nxt = ST_LOAD;
            else if (w_rev_chg)
               w_state_nxt = ST_IDLE;
         end
         ST_LOAD: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_speed_nxt = r_speed;
      if (w_rise[4] && !w_rise[5] && r_speed != 2'd3)
         w_speed_nxt = r_speed + 2'd1;
      else if (w_rise[5] && !w_rise[4] && r_speed != 2'd0)
         w_speed_nxt = r_speed - 2'd1;
   end

   assign w_lim = LIM0 >> r_speed;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if ((w_state_nxt != r_state) || (w_speed_nxt != r_speed) || w_rev_chg)
         w_cnt_nxt = '0;
      else if (r_state == ST_RUN)
         w_cnt_nxt = (r_cnt == w_lim) ? '0 : r_cnt + CW'(1);
   end

   always_ff @(posedge clk_in or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= ST_IDLE;
         r_prev     <= '0;
         r_speed    <= '0;
         r_cnt      <= '0;
         r_load_sel <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_prev  <= w_lvl;
         r_speed <= w_speed_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_state_nxt == ST_LOAD)
            r_load_sel <= w_sel_nxt;
      end
   end

   // Masked combinationally so the cycle AT_LIMIT rises never emits a tick.
   assign TICK_EN  = (r_state == ST_RUN) && (r_cnt == w_lim) && !AT_LIMIT;
   assign LOAD     = (r_state == ST_LOAD);
   assign RUNNING  = (r_state == ST_RUN);
   assign LOAD_SEL = r_load_sel;
   assign SPEED    = r_speed;
   assign STATE    = r_state;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the BCD stopwatch datapath. It turns raw button/switch levels into the counter chain's tick enable, load strobe and load-source select, and owns the run/pause/limit state and the speed-selectable tick prescaler. It sits between the board inputs and the digit counters, comparator and preset/adder mux, and replaces ad-hoc gating of START/RESET/ADD/SUBTRACT.

## Interface
- TICK_DIV, 1000: clk_in cycles per tick at speed 0; must be a multiple of 8 and ≥ 8.
- clk_in  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START_BTN  in  1  run/pause toggle button (level; rising edge acts).
- RESET_BTN  in  1  clear-to-preset button (rising edge).
- ADD_BTN  in  1  increment-load button (rising edge).
- SUB_BTN  in  1  decrement-load button (rising edge).
- SPEED_UP  in  1  speed level +1 (rising edge).
- SPEED_DOWN  in  1  speed level −1 (rising edge).
- REVERSE  in  1  count direction switch, level (1 = count down).
- AT_LIMIT  in  1  datapath comparator: displayed value equals stop value for current direction.
- TICK_EN  out  1  one-cycle count pulse to the least-significant digit counter.
- LOAD  out  1  one-cycle load strobe to the digit counters.
- LOAD_SEL  out  2  source during LOAD: 00 up-preset, 01 down-preset, 10 adder +, 11 adder −.
- RUNNING  out  1  high in RUN.
- SPEED  out  2  current speed level.
- STATE  out  3  FSM state code.

## Operation
- Button events: rising edge of each button, detected by a one-register edge detector.
- States: IDLE=000, RUN=001, PAUSE=010, LIMIT=011, LOAD=100.
- Event priority per cycle: RESET_BTN > SUB_BTN > ADD_BTN > START_BTN; lower events the same cycle are dropped.
- IDLE: START → RUN if AT_LIMIT=0, else → LIMIT; RESET/SUB/ADD → LOAD.
- RUN: START → PAUSE; RESET → LOAD; ADD/SUB ignored; AT_LIMIT=1 → LIMIT.
- PAUSE: START → RUN (AT_LIMIT=0) or LIMIT (AT_LIMIT=1); RESET/SUB/ADD → LOAD.
- LIMIT: START ignored; RESET/SUB/ADD → LOAD; REVERSE level change → IDLE.
- LOAD: one cycle, LOAD=1; always → IDLE next cycle.
- LOAD_SEL: RESET gives {1'b0,REVERSE}; ADD gives 10; SUB gives 11. It is registered with the transition into LOAD and held until the next LOAD.
- Speed: level 0..3, saturating; SPEED_UP and SPEED_DOWN in the same cycle cancel. Divisor = TICK_DIV >> SPEED.
- Prescaler: counts only in RUN, from 0 to divisor−1, then wraps. It is cleared on every state change, on any SPEED change and on any REVERSE change.
- TICK_EN = RUN & (count == divisor−1) & ~AT_LIMIT. It is combinationally masked, so no tick is emitted in the cycle AT_LIMIT rises.

## Timing
- Reset values: STATE=IDLE, TICK_EN=0, LOAD=0, LOAD_SEL=00, RUNNING=0, SPEED=00, prescaler=0.
- Event latency: button high at cycle k after being low at k−1 → new STATE visible at k+1 (k+3 with sync enabled).
- First TICK_EN after entering RUN arrives exactly divisor cycles later, then every divisor cycles.
- LOAD is high for exactly one cycle; TICK_EN is never high while LOAD is high.
- A SPEED change in RUN restarts the period: next tick comes divisor_new cycles after the change.
- RESET_N asserted mid-LOAD: LOAD drops immediately (asynchronous) and state returns to IDLE.

## Configuration
- STOPWATCH_CTRL_SYNC_EN defined: every button input and REVERSE passes through a 2-flop synchronizer ahead of the edge detector, adding 2 cycles of event latency. AT_LIMIT is not synchronized.
- Not defined: inputs are treated as synchronous to clk_in and drive the edge detectors directly.

## Test plan
- TICK_DIV=8, speed 0: reset, pulse START → STATE=001, TICK_EN pulses every 8 cycles, first pulse 8 cycles after entry.
- In RUN, pulse SPEED_UP ×3 then once more → SPEED=11 (saturated), TICK_EN period 1 cycle; SPEED_DOWN ×4 → SPEED=00, period 8.
- In RUN, raise AT_LIMIT on the cycle the prescaler equals 7 → no TICK_EN, STATE=011 next cycle; START pulse → stays 011.
- In LIMIT, pulse RESET_BTN with REVERSE=1 → one cycle STATE=100 with LOAD=1 and LOAD_SEL=01, then STATE=000.
- In PAUSE, press ADD_BTN and SUB_BTN in the same cycle → single LOAD with LOAD_SEL=11; ADD press in RUN → no LOAD.
- Assert RESET_N low in the LOAD cycle → LOAD=0 and STATE=000 immediately; SPEED=00. With STOPWATCH_CTRL_SYNC_EN, START → RUN latency is 3 cycles.
